// File: rtl/pixel_unpacker.sv
// -----------------------------------------------------------------------------
// pixel_unpacker
//
// Purpose:
//   Unpacks a byte stream from a first-word-fall-through FIFO into 24-bit
//   pixels. Three bytes are popped in R, G, B order and the assembled pixel
//   is offered downstream with a valid/ready handshake. Line and frame
//   position are tracked so the last pixel of each line (pix_eol) and of
//   each frame (pix_eof) are flagged.
//
// Parameters:
//   H_PIX  pixels per line  (default 160)
//   V_PIX  lines per frame  (default 120)
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-low reset
//   fifo_empty   in   upstream FIFO empty flag
//   fifo_r_data  in   upstream FIFO head byte (valid while fifo_empty=0)
//   fifo_rd      out  pop strobe to upstream FIFO (combinational)
//   pix_valid    out  pixel available downstream
//   pix_ready    in   downstream accepts pixel
//   pix_data     out  pixel {R,G,B}, R in [23:16]
//   pix_eol      out  current pixel is last of its line
//   pix_eof      out  current pixel is last of its frame
//
// Configuration macro:
//   PIXEL_UNPACKER_GRAY_EN  when defined, pix_data carries {Y,Y,Y} with
//                           Y = (R + 2G + B) >> 2 instead of {R,G,B}.
//
// FSM states:
//   state  | meaning
//   -------+---------------------------------------------------
//   GET_R  | waiting for / popping the red byte
//   GET_G  | waiting for / popping the green byte
//   GET_B  | waiting for / popping the blue byte, loads outputs
//   SEND   | pixel presented, waiting for pix_ready
// -----------------------------------------------------------------------------
module pixel_unpacker #(
  parameter int H_PIX = 160,
  parameter int V_PIX = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_r_data,
  output logic        fifo_rd,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_data,
  output logic        pix_eol,
  output logic        pix_eof
);

  localparam int COL_W = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int ROW_W = (V_PIX > 1) ? $clog2(V_PIX) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIX - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_PIX - 1);

  typedef enum logic [1:0] {
    GET_R = 2'd0,
    GET_G = 2'd1,
    GET_B = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t           r_state;
  logic [7:0]       r_byte_r;
  logic [7:0]       r_byte_g;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  logic             w_pop;
  logic             w_hs;
  logic             w_col_last;
  logic             w_row_last;
  logic [23:0]      w_pix_next;

  // Popping is allowed in every GET state; the reset gate keeps the strobe
  // quiet while the block is held in reset even though the state is GET_R.
  assign w_pop   = (r_state != SEND) & ~fifo_empty;
  assign fifo_rd = reset & w_pop;

  assign w_hs       = pix_valid & pix_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  // The blue byte is never held separately: it is taken straight from the
  // FIFO head on the GET_B pop and lands in the pix_data register, which
  // avoids a cycle of latency between the last pop and pix_valid.
`ifdef PIXEL_UNPACKER_GRAY_EN
  logic [9:0] w_luma_sum;
  logic [7:0] w_luma;

  // 10 bits hold the worst case 4*255 = 1020 without overflow.
  assign w_luma_sum = {2'b00, r_byte_r} + {1'b0, r_byte_g, 1'b0} + {2'b00, fifo_r_data};
  assign w_luma     = w_luma_sum[9:2];
  assign w_pix_next = {w_luma, w_luma, w_luma};
`else
  assign w_pix_next = {r_byte_r, r_byte_g, fifo_r_data};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= GET_R;
      r_byte_r  <= 8'h00;
      r_byte_g  <= 8'h00;
      r_col     <= '0;
      r_row     <= '0;
      pix_valid <= 1'b0;
      pix_data  <= 24'h000000;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
    end else begin
      case (r_state)
        GET_R: begin
          if (w_pop) begin
            r_byte_r <= fifo_r_data;
            r_state  <= GET_G;
          end
        end

        GET_G: begin
          if (w_pop) begin
            r_byte_g <= fifo_r_data;
            r_state  <= GET_B;
          end
        end

        GET_B: begin
          if (w_pop) begin
            pix_data  <= w_pix_next;
            pix_valid <= 1'b1;
            // Flags reflect the position of the pixel being presented; the
            // counters only move once it has been accepted.
            pix_eol   <= w_col_last;
            pix_eof   <= w_col_last & w_row_last;
            r_state   <= SEND;
          end
        end

        SEND: begin
          if (w_hs) begin
            pix_valid <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
            r_state   <= GET_R;
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_row <= '0;
              end else begin
                r_row <= r_row + ROW_W'(1);
              end
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end

        default: begin
          r_state <= GET_R;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_unpacker.sv
module tb_pixel_unpacker;

  localparam int H = 4;
  localparam int V = 2;

`ifdef PIXEL_UNPACKER_GRAY_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        fifo_empty;
  logic [7:0]  fifo_r_data;
  logic        fifo_rd;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic        pix_eol;
  logic        pix_eof;

  pixel_unpacker #(.H_PIX(H), .V_PIX(V)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_r_data (fifo_r_data),
    .fifo_rd     (fifo_rd),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus knobs
  logic        in_rst   = 1'b0;  // value driven onto reset (0 = in reset)
  logic        in_stall = 1'b0;  // force fifo_empty even if bytes queued
  logic        in_ready = 1'b0;

  // Upstream FIFO contents and reference model state
  logic [7:0]  src_q[$];   // bytes not yet popped
  logic [7:0]  pend[$];    // bytes popped since last accepted pixel / reset
  int          pix_idx;    // pixels accepted since reset

  // Per-cycle samples
  logic        s_rd, s_valid, s_eol, s_eof;
  logic [23:0] s_data;
  logic        hs_seen;
  logic [23:0] hs_data;
  logic        hs_eol, hs_eof;
  int          hs_count;

  typedef struct {
    logic [7:0]  r, g, b;
    logic [23:0] exp_raw;
    logic [23:0] exp_gray;
    logic        exp_eol;
    logic        exp_eof;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [23:0] px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int y;
    logic [7:0] yy;
    if (GRAY) begin
      y  = (int'(r) + 2 * int'(g) + int'(b)) / 4;
      yy = 8'(y);
      return {yy, yy, yy};
    end
    return {r, g, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample and compare against the model,
  // then let the rising edge happen and update the model.
  task automatic step();
    logic       e_valid, e_rd, e_eol, e_eof;
    logic [23:0] e_data;
    @(negedge clk);
    reset       = in_rst;
    fifo_empty  = in_stall || (src_q.size() == 0);
    fifo_r_data = (src_q.size() != 0) ? src_q[0] : 8'h00;
    pix_ready   = in_ready;
    #1;
    s_rd    = fifo_rd;
    s_valid = pix_valid;
    s_eol   = pix_eol;
    s_eof   = pix_eof;
    s_data  = pix_data;

    e_valid = in_rst && (pend.size() == 3);
    e_rd    = in_rst && !e_valid && !fifo_empty;
    e_eol   = e_valid && ((pix_idx % H) == H - 1);
    e_eof   = e_eol && (((pix_idx / H) % V) == V - 1);

    chk("fifo_rd", 32'(s_rd), 32'(e_rd));
    chk("pix_valid", 32'(s_valid), 32'(e_valid));
    chk("pix_eol", 32'(s_eol), 32'(e_eol));
    chk("pix_eof", 32'(s_eof), 32'(e_eof));
    if (!in_rst) begin
      chk("pix_data_reset", 32'(s_data), 32'h0);
    end else if (e_valid) begin
      e_data = px(pend[0], pend[1], pend[2]);
      chk("pix_data", 32'(s_data), 32'(e_data));
    end

    if (s_valid && in_ready && in_rst) begin
      hs_seen = 1'b1;
      hs_data = s_data;
      hs_eol  = s_eol;
      hs_eof  = s_eof;
      hs_count++;
    end

    @(posedge clk);
    if (!in_rst) begin
      pend.delete();
      pix_idx = 0;
    end else if (s_rd) begin
      if (src_q.size() != 0) pend.push_back(src_q.pop_front());
    end else if (e_valid && in_ready) begin
      void'(pend.pop_front());
      void'(pend.pop_front());
      void'(pend.pop_front());
      pix_idx++;
    end
  endtask

  task automatic do_reset();
    in_rst = 1'b0;
    src_q.delete();
    step();
    step();
    in_rst = 1'b1;
  endtask

  task automatic wait_hs(input string name, input int budget);
    hs_seen = 1'b0;
    for (int i = 0; i < budget && !hs_seen; i++) step();
    if (!hs_seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic push3(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    src_q.push_back(r);
    src_q.push_back(g);
    src_q.push_back(b);
  endtask

  initial begin
    int rd_cnt, v_cnt, hs0;
    logic [23:0] held;

    vecs[0] = '{8'h11, 8'h22, 8'h33, 24'h112233, 24'h222222, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 24'h00FF00, 24'h7F7F7F, 1'b0, 1'b0};
    vecs[3] = '{8'hA0, 8'hB0, 8'hC0, 24'hA0B0C0, 24'hB0B0B0, 1'b1, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 8'h56, 24'h123456, 24'h343434, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 8'h02, 8'h03, 24'h010203, 24'h020202, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 8'hFF, 24'hFF00FF, 24'h7F7F7F, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 8'h80, 24'h808080, 24'h808080, 1'b1, 1'b1};
    vecs[8] = '{8'h03, 8'h00, 8'h00, 24'h030000, 24'h000000, 1'b0, 1'b0};

    reset = 1'b0; fifo_empty = 1'b0; fifo_r_data = 8'h5A; pix_ready = 1'b1;
    pix_idx = 0; hs_count = 0; hs_seen = 1'b0;
    #2;
    chk("rst_fifo_rd", 32'(fifo_rd), 32'h0);
    chk("rst_pix_valid", 32'(pix_valid), 32'h0);
    chk("rst_pix_data", 32'(pix_data), 32'h0);
    do_reset();

    // Basic pixel: three pops, one valid cycle
    in_ready = 1'b1; in_stall = 1'b0;
    push3(8'h11, 8'h22, 8'h33);
    rd_cnt = 0; v_cnt = 0; hs_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      rd_cnt += int'(s_rd);
      v_cnt  += int'(s_valid);
    end
    chk("basic_rd_cycles", 32'(rd_cnt), 32'd3);
    chk("basic_valid_cycles", 32'(v_cnt), 32'd1);
    chk("basic_data", 32'(hs_data), GRAY ? 32'h222222 : 32'h112233);

    // Table: one frame plus one pixel at H=4, V=2
    do_reset();
    in_ready = 1'b1;
    foreach (vecs[i]) begin
      push3(vecs[i].r, vecs[i].g, vecs[i].b);
      wait_hs("vec_hs", 20);
      chk($sformatf("vec%0d_data", i), 32'(hs_data), 32'(GRAY ? vecs[i].exp_gray : vecs[i].exp_raw));
      chk($sformatf("vec%0d_eol", i), 32'(hs_eol), 32'(vecs[i].exp_eol));
      chk($sformatf("vec%0d_eof", i), 32'(hs_eof), 32'(vecs[i].exp_eof));
    end

    // Backpressure: pixel held for 10 cycles with more bytes waiting
    do_reset();
    in_ready = 1'b0;
    push3(8'h5A, 8'hC3, 8'h0F);
    push3(8'h21, 8'h43, 8'h65);
    for (int i = 0; i < 10 && !s_valid; i++) step();
    chk("bp_valid_reached", 32'(s_valid), 32'd1);
    held = s_data;
    chk("bp_first_data", 32'(held), 32'(px(8'h5A, 8'hC3, 8'h0F)));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", 32'(s_valid), 32'd1);
      chk("bp_hold_rd", 32'(s_rd), 32'd0);
      chk("bp_hold_data", 32'(s_data), 32'(held));
    end
    hs0 = hs_count;
    in_ready = 1'b1;
    step();
    step();
    chk("bp_valid_drop", 32'(s_valid), 32'd0);
    in_ready = 1'b0;
    step();
    chk("bp_single_hs", 32'(hs_count - hs0), 32'd1);
    in_ready = 1'b1;
    wait_hs("bp_second_hs", 20);
    chk("bp_second_data", 32'(hs_data), 32'(px(8'h21, 8'h43, 8'h65)));

    // Reset with a partially captured pixel
    do_reset();
    in_ready = 1'b1;
    src_q.push_back(8'h5C);
    src_q.push_back(8'h6D);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("partial_no_valid", 32'(s_valid), 32'd0);
    end
    @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_rd", 32'(fifo_rd), 32'd0);
    chk("async_rst_valid", 32'(pix_valid), 32'd0);
    chk("async_rst_data", 32'(pix_data), 32'd0);
    in_rst = 1'b0;
    step();
    in_rst = 1'b1;
    push3(8'hA0, 8'hB0, 8'hC0);
    wait_hs("partial_hs", 20);
    chk("partial_data", 32'(hs_data), GRAY ? 32'hB0B0B0 : 32'hA0B0C0);
    chk("partial_eol", 32'(hs_eol), 32'd0);

    // Randomized traffic against the model
    do_reset();
    hs0 = hs_count;
    for (int i = 0; i < 6000; i++) begin
      while (src_q.size() < 4) src_q.push_back(8'($urandom));
      in_stall = ($urandom_range(0, 9) < 3);
      in_ready = ($urandom_range(0, 9) < 6);
      in_rst   = ($urandom_range(0, 499) != 0);
      step();
    end
    in_rst = 1'b1;
    chk("random_progress", 32'(hs_count - hs0 > 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
